// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared types and constants for the rng_collector block
//
// Purpose:
//   Collector FSM state type, discard counter width, default parameter values
//   and a counter-width helper used by rng_collector.
// Ports: none (package).

package rng_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PAIR_A = 2'd1,
    PAIR_B = 2'd2,
    HOLD   = 2'd3
  } rng_state_t;

  localparam int DISCARD_W      = 16;
  localparam int REP_W          = 16;
  localparam int DEF_WORD_W     = 8;
  localparam int DEF_SAMPLE_DIV = 4;
  localparam int DEF_REP_LIMIT  = 32;

  // Width of a counter holding 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rng_bit_sync.sv
// rtl/rng_bit_sync.sv - two-flop synchroniser for the asynchronous raw entropy bit
//
// Purpose:
//   Brings a free-running single bit into the clk_i domain with a 2-cycle latency.
// Ports:
//   clk_i  in   destination clock
//   rst_i  in   asynchronous active-high reset, clears both stages to 0
//   d_i    in   asynchronous input bit
//   q_o    out  synchronised bit

module rng_bit_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rng_collector.sv
// rtl/rng_collector.sv - ring-oscillator entropy collector with von Neumann extraction
//
// Purpose:
//   Resynchronises raw_bit, samples it once every SAMPLE_DIV enabled cycles,
//   removes bias with a von Neumann pair extractor, packs accepted bits MSB-first
//   into WORD_W-bit words and offers them over a valid/ready handshake. A
//   repetition-count health test latches a sticky failure flag.
// Ports:
//   clk_5M       in   sole clock
//   reset        in   asynchronous active-high reset
//   enable       in   collection enable
//   raw_bit      in   asynchronous raw entropy bit
//   word_out     out  assembled word, stable while word_valid=1
//   word_valid   out  word available
//   word_ready   in   consumer accepts word when word_valid & word_ready
//   health_fail  out  sticky repetition-test failure
//   discard_cnt  out  saturating count of rejected equal pairs

module rng_collector
  import rng_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int REP_LIMIT  = DEF_REP_LIMIT
) (
  input  logic                 clk_5M,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 raw_bit,
  output logic [WORD_W-1:0]    word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 health_fail,
  output logic [DISCARD_W-1:0] discard_cnt
);

  localparam int DIV_W = cnt_width(SAMPLE_DIV - 1);
  localparam int BIT_W = cnt_width(WORD_W);

  logic             raw_s;
  logic             tick;
  logic [DIV_W-1:0] div_q;
  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] rep_d;
  logic             prev_q;
  logic             a_q;
  logic [BIT_W-1:0] bit_cnt_q;
  rng_state_t       state_q;

  rng_bit_sync u_sync (
    .clk_i (clk_5M),
    .rst_i (reset),
    .d_i   (raw_bit),
    .q_o   (raw_s)
  );

  // Sample tick divider; parked at 0 while disabled so the first tick after
  // enabling always lands SAMPLE_DIV cycles later.
  assign tick = enable && (div_q == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk_5M or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (!enable || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Repetition count: rep_q==0 marks "no sample seen since IDLE", so the first
  // tick always restarts the run at 1.
  always_comb begin
    rep_d = REP_W'(1);
    if (rep_q != '0 && raw_s == prev_q) begin
      rep_d = (rep_q == '1) ? rep_q : rep_q + REP_W'(1);
    end
  end

  always_ff @(posedge clk_5M or posedge reset) begin
    if (reset) begin
      rep_q       <= '0;
      prev_q      <= 1'b0;
      health_fail <= 1'b0;
    end else if (state_q == IDLE) begin
      rep_q <= '0;
    end else if (tick) begin
      rep_q  <= rep_d;
      prev_q <= raw_s;
      if (rep_d == REP_W'(REP_LIMIT)) begin
        health_fail <= 1'b1;
      end
    end
  end

  // Collector FSM. health_fail is the registered flag, so a handshake or pair
  // completing on the same edge the failure latches still takes effect.
  always_ff @(posedge clk_5M or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= 1'b0;
      bit_cnt_q   <= '0;
      word_out    <= '0;
      word_valid  <= 1'b0;
      discard_cnt <= '0;
    end else if (health_fail) begin
      state_q    <= IDLE;
      word_valid <= 1'b0;
      bit_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          word_valid <= 1'b0;
          bit_cnt_q  <= '0;
          if (enable) begin
            state_q <= PAIR_A;
          end
        end

        PAIR_A: begin
          if (!enable) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
          end else if (tick) begin
            a_q     <= raw_s;
            state_q <= PAIR_B;
          end
        end

        PAIR_B: begin
          if (!enable) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
          end else if (tick) begin
            if (a_q != raw_s) begin
              // Keep the first bit of a 01/10 pair, shifting in MSB-first.
              word_out <= {word_out[WORD_W-2:0], a_q};
              if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
                bit_cnt_q  <= BIT_W'(WORD_W);
                word_valid <= 1'b1;
                state_q    <= HOLD;
              end else begin
                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                state_q   <= PAIR_A;
              end
            end else begin
              if (discard_cnt != '1) begin
                discard_cnt <= discard_cnt + DISCARD_W'(1);
              end
              state_q <= PAIR_A;
            end
          end
        end

        HOLD: begin
          // The word waits for the consumer even if enable drops meanwhile.
          if (word_ready) begin
            word_valid <= 1'b0;
            bit_cnt_q  <= '0;
            state_q    <= enable ? PAIR_A : IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_collector.sv
// tb/tb_rng_collector.sv - scoreboard testbench for rng_collector

module tb_rng_collector;
  import rng_pkg::*;

  localparam int WW = 8;
  localparam int SD = 4;
  localparam int RL = 32;

  logic          clk_5M = 1'b0;
  logic          reset;
  logic          enable;
  logic          raw_bit;
  logic          word_ready;
  logic [WW-1:0] word_out;
  logic          word_valid;
  logic          health_fail;
  logic [15:0]   discard_cnt;

  always #5 clk_5M = ~clk_5M;

  rng_collector #(
    .WORD_W     (WW),
    .SAMPLE_DIV (SD),
    .REP_LIMIT  (RL)
  ) dut (
    .clk_5M      (clk_5M),
    .reset       (reset),
    .enable      (enable),
    .raw_bit     (raw_bit),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .health_fail (health_fail),
    .discard_cnt (discard_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [WW-1:0] exp_q[$];

  // Reference model state: sample stream split into pairs, run length of
  // identical samples, and the word being assembled.
  int            m_nb;
  int            m_run;
  int            m_disc;
  bit            m_prev;
  bit            m_a;
  bit            m_have_a;
  bit            m_fail;
  logic [WW-1:0] m_word;

  bit            hold_chk = 1'b0;
  logic [WW-1:0] hold_word;
  int            valid_cycles = 0;
  bit            hs_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_nb = 0; m_run = 0; m_disc = 0; m_prev = 0; m_a = 0;
    m_have_a = 0; m_fail = 0; m_word = '0;
    exp_q.delete();
  endfunction

  function automatic void model_idle();
    m_nb = 0; m_have_a = 0; m_run = 0;
  endfunction

  function automatic void model_health(input bit b);
    if (m_fail) return;
    m_run  = (m_run != 0 && b == m_prev) ? m_run + 1 : 1;
    m_prev = b;
    if (m_run >= RL) m_fail = 1;
  endfunction

  function automatic void model_sample(input bit b);
    if (m_fail) return;
    if (!m_have_a) begin
      m_a = b;
      m_have_a = 1;
    end else begin
      m_have_a = 0;
      if (m_a != b) begin
        m_word = {m_word[WW-2:0], m_a};
        m_nb++;
        if (m_nb == WW) begin
          exp_q.push_back(m_word);
          m_nb = 0;
        end
      end else if (m_disc < 65535) begin
        m_disc++;
      end
    end
    model_health(b);
  endfunction

  // One raw sample per tick window; called at a negedge, returns at the
  // negedge after the tick edge that consumed the sample.
  task automatic drive_sample(input bit b, input bit extract);
    raw_bit = b;
    repeat (SD) @(posedge clk_5M);
    if (extract) model_sample(b);
    else model_health(b);
    @(negedge clk_5M);
  endtask

  task automatic drive_pair(input bit x, input bit y);
    drive_sample(x, 1'b1);
    drive_sample(y, 1'b1);
  endtask

  task automatic drive_word(input logic [WW-1:0] w);
    for (int i = WW - 1; i >= 0; i--) drive_pair(w[i], !w[i]);
  endtask

  task automatic async_reset_check(input string tag);
    @(negedge clk_5M);
    #2 reset = 1'b1;
    #1;
    check({tag, "_word_out"}, 32'(word_out), 0);
    check({tag, "_word_valid"}, 32'(word_valid), 0);
    check({tag, "_health_fail"}, 32'(health_fail), 0);
    check({tag, "_discard_cnt"}, 32'(discard_cnt), 0);
    model_reset();
    enable   = 1'b0;
    hold_chk = 1'b0;
    @(negedge clk_5M);
    @(negedge clk_5M);
    reset = 1'b0;
    repeat (2) @(negedge clk_5M);
    check({tag, "_fsm_idle"}, 32'(dut.state_q), 32'(IDLE));
  endtask

  // Monitor: pops the scoreboard on every accepted word.
  always @(negedge clk_5M) begin
    #1;
    if (reset) begin
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) check("valid_drop_after_accept", 32'(word_valid), 0);
      hs_prev = word_valid && word_ready;
      if (word_valid) valid_cycles++;
      if (word_valid && word_ready) begin
        check("word_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          logic [WW-1:0] e;
          e = exp_q.pop_front();
          check("word", 32'(word_out), 32'(e));
        end
      end
      if (hold_chk) begin
        check("hold_valid", 32'(word_valid), 1);
        check("hold_word", 32'(word_out), 32'(hold_word));
      end
    end
  end

  initial begin
    int            vc0;
    int            run;
    bit            last;
    bit            b;
    logic [WW-1:0] w;

    reset = 1'b1; enable = 1'b0; raw_bit = 1'b0; word_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk_5M);
    @(negedge clk_5M);
    reset = 1'b0;
    check("rst_word_out", 32'(word_out), 0);
    check("rst_word_valid", 32'(word_valid), 0);
    check("rst_health_fail", 32'(health_fail), 0);
    check("rst_discard_cnt", 32'(discard_cnt), 0);
    check("rst_fsm_idle", 32'(dut.state_q), 32'(IDLE));

    // A5 from clean pairs, single-cycle valid pulse.
    enable = 1'b1;
    vc0 = valid_cycles;
    drive_word(8'hA5);
    check("a5_word", 32'(word_out), 32'h0A5);
    check("a5_valid", 32'(word_valid), 1);
    check("a5_discard", 32'(discard_cnt), 0);

    // Equal pairs discarded, then an all-zero word.
    drive_pair(1'b1, 1'b1);
    check("a5_pulse_len", 32'(valid_cycles - vc0), 1);
    drive_pair(1'b0, 1'b0);
    drive_pair(1'b1, 1'b1);
    drive_word(8'h00);
    check("zero_word", 32'(word_out), 0);
    check("zero_discard", 32'(discard_cnt), 3);
    check("zero_discard_model", 32'(discard_cnt), 32'(m_disc));

    // Back-pressure: word held for 100 cycles, then accepted.
    w = WW'($urandom);
    drive_pair(w[WW-1], !w[WW-1]);
    word_ready = 1'b0;
    for (int i = WW - 2; i >= 0; i--) drive_pair(w[i], !w[i]);
    hold_word = w;
    hold_chk  = 1'b1;
    for (int i = 0; i < 25; i++) drive_sample(1'(i % 2), 1'b0);
    hold_chk   = 1'b0;
    word_ready = 1'b1;

    // Partial word dropped by enable=0, then 3C with no stale bits.
    for (int i = 0; i < 5; i++) drive_pair(1'b1, 1'b0);
    enable = 1'b0;
    model_idle();
    repeat (10) @(negedge clk_5M);
    check("dis_no_valid", 32'(word_valid), 0);
    enable = 1'b1;
    drive_word(8'h3C);
    check("word_3c", 32'(word_out), 32'h03C);
    check("word_3c_model", 32'(word_out), 32'(m_word));

    // Randomized stream, runs capped well below the health limit.
    run = 0; last = 1'b0;
    for (int i = 0; i < 240; i++) begin
      b = 1'($urandom_range(0, 1));
      if (run >= 8 && b == last) b = !b;
      run  = (b == last) ? run + 1 : 1;
      last = b;
      drive_sample(b, 1'b1);
    end
    check("rand_discard", 32'(discard_cnt), 32'(m_disc));
    check("rand_health", 32'(health_fail), 0);

    async_reset_check("midrst");

    // Constant 1: repetition test trips on the 32nd tick.
    enable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      drive_sample(1'b1, 1'b1);
      check("rep_health_model", 32'(health_fail), 32'(m_fail));
      check("rep_no_valid", 32'(word_valid), 0);
      if (k == 31) begin
        check("rep_health_t31", 32'(health_fail), 0);
        check("rep_discard_t31", 32'(discard_cnt), 15);
      end
      if (k == 32) check("rep_health_t32", 32'(health_fail), 1);
    end
    for (int i = 0; i < 10; i++) drive_sample(1'(i % 2), 1'b1);
    check("fail_discard_frozen", 32'(discard_cnt), 32'(m_disc));
    check("fail_sticky", 32'(health_fail), 1);
    check("fail_fsm_idle", 32'(dut.state_q), 32'(IDLE));

    async_reset_check("failrst");

    // Recovery after reset.
    enable = 1'b1;
    w = WW'($urandom);
    drive_word(w);
    check("recover_word", 32'(word_out), 32'(w));
    repeat (3) @(negedge clk_5M);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rng_collector.md
Name: rng_collector

Overview:
- Consumer end of the ring-oscillator entropy bit `f`.
- Resynchronises the free-running raw bit into the `clk_5M` domain and samples it at a fixed divided rate.
- Removes bias with a von Neumann pair extractor and packs unbiased bits into words.
- Delivers words over a valid/ready handshake, and runs a repetition-count health test that latches a sticky failure flag.

Parameters:
- WORD_W, 8: output word width in bits (2..32).
- SAMPLE_DIV, 4: `clk_5M` cycles per raw sample tick (>=1).
- REP_LIMIT, 32: consecutive identical raw samples that trip `health_fail` (2..65535).

Ports:
- clk_5M  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  collection enable (synchronous to `clk_5M`).
- raw_bit  in  1  asynchronous raw entropy bit from the oscillator sampler.
- word_out  out  WORD_W  assembled word; stable while word_valid=1.
- word_valid  out  1  word available.
- word_ready  in  1  consumer accepts word when word_valid & word_ready.
- health_fail  out  1  sticky repetition-test failure.
- discard_cnt  out  16  count of rejected equal pairs (00/11); saturates at 16'hFFFF.

Behaviour:
- Reset (async, immediate):
  - raw_s, word_out, word_valid, health_fail, discard_cnt, all counters = 0.
  - FSM = IDLE.
- Synchroniser: 2-flop chain, raw_bit -> raw_s. 2-cycle latency.
- Tick divider:
  - div_cnt counts 0..SAMPLE_DIV-1 while enable=1; tick=1 when div_cnt==SAMPLE_DIV-1.
  - div_cnt held at 0 while enable=0.
  - With SAMPLE_DIV=1, tick=1 every enabled cycle.
- Health test (every tick, in all non-IDLE states including HOLD):
  - If raw_s==prev then rep_cnt++, else rep_cnt=1. prev<=raw_s.
  - First tick after IDLE sets rep_cnt=1.
  - When rep_cnt reaches REP_LIMIT, health_fail<=1 on that clock edge.
  - health_fail is cleared only by reset.
- FSM states:
  - IDLE:
    - bit_cnt=0, word_valid=0.
    - enable=1 & health_fail=0 -> PAIR_A.
  - PAIR_A: on tick, a<=raw_s -> PAIR_B.
  - PAIR_B: on tick, compare a with raw_s.
    - If a!=raw_s: word_out<={word_out[WORD_W-2:0], a} (first bit of pair, MSB-first fill), bit_cnt++.
      - If bit_cnt becomes WORD_W -> HOLD, with word_valid=1 from the next cycle.
      - Otherwise -> PAIR_A.
    - If a==raw_s: discard_cnt++ (saturating) -> PAIR_A.
  - enable=0 in PAIR_A/PAIR_B -> IDLE next clock; the partial word is discarded (bit_cnt=0).
  - HOLD:
    - word_valid=1; word_out frozen; ticks ignored for extraction.
    - On word_valid&word_ready: word_valid<=0, bit_cnt<=0, then -> PAIR_A if enable=1, else IDLE.
    - enable=0 while in HOLD does not drop the word; it waits for acceptance.
- health_fail=1 in any state -> IDLE next clock; word_valid drops; the pending word is lost.
  - Exception: if word_valid&word_ready occur in the same cycle the failure latches, that transfer counts as completed.
- Throughput: at most one pair per 2*SAMPLE_DIV cycles. A word needs >= WORD_W accepted pairs.
- Latency: word_valid rises exactly 1 clock after the tick that completes the WORD_W-th accepted pair.

Decomposition:
- Package rng_pkg:
  - `rng_state_t` enum {IDLE, PAIR_A, PAIR_B, HOLD}.
  - DISCARD_W=16 constant.
  - Default WORD_W/SAMPLE_DIV/REP_LIMIT constants.
- One sub-module: rng_bit_sync (2-flop synchroniser, async active-high reset to 0).

Test Plan:
- Reset asserted mid-run -> word_out=0, word_valid=0, health_fail=0, discard_cnt=0 the same cycle. FSM IDLE after release.
- WORD_W=8, SAMPLE_DIV=4; raw_bit held per tick as pairs (1,0),(0,1),(1,0),(0,1),(0,1),(1,0),(0,1),(1,0), word_ready=1 -> word_out=8'hA5, a single 1-cycle word_valid pulse, discard_cnt=0.
- Pairs (1,1),(0,0),(1,1) interleaved before 8 pairs of (0,1) -> word_out=8'h00, discard_cnt=3.
- raw_bit constant 1, REP_LIMIT=32 -> health_fail stays 0 through tick 31 and is 1 after tick 32. No word_valid afterwards; discard_cnt=15 at tick 31, and no further extraction once the FSM returns to IDLE.
- Word complete with word_ready=0 for 100 cycles -> word_out and word_valid stable throughout. Raise word_ready -> word_valid=0 the next cycle and collection resumes.
- 5 accepted bits, then enable=0 for 10 cycles, then enable=1 and 8 pairs giving 8'h3C -> word_out=8'h3C, containing no stale bits.
